// File: rtl/trade_pkg.sv
// rtl/trade_pkg.sv - shared price width, trade entry record and price limits
package trade_pkg;

  localparam int PRICE_W = 8;

  localparam logic [PRICE_W-1:0] PRICE_MIN = '0;
  localparam logic [PRICE_W-1:0] PRICE_MAX = '1;

  typedef struct packed {
    logic [PRICE_W-1:0] price;
    logic [PRICE_W-1:0] bid;
    logic [PRICE_W-1:0] ask;
  } trade_entry_t;

endpackage

// File: rtl/trade_history_if.sv
// rtl/trade_history_if.sv - trade capture, indexed read and statistics signal bundle
interface trade_history_if #(
  parameter int DEPTH   = 16,
  parameter int PRICE_W = 8
);
  localparam int IDX_W = $clog2(DEPTH);

  logic               match_signal;
  logic               enable_count;
  logic [PRICE_W-1:0] trade_price;
  logic [PRICE_W-1:0] best_bid;
  logic [PRICE_W-1:0] best_ask;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_valid;
  logic               rd_hit;
  logic [PRICE_W-1:0] rd_price;
  logic [PRICE_W-1:0] rd_bid;
  logic [PRICE_W-1:0] rd_ask;
  logic [IDX_W:0]     count;
  logic               wrapped;
  logic [PRICE_W-1:0] last_price;
  logic [PRICE_W-1:0] high_price;
  logic [PRICE_W-1:0] low_price;
  logic               stats_valid;

  modport master (
    output match_signal, enable_count, trade_price, best_bid, best_ask, rd_en, rd_idx,
    input  rd_valid, rd_hit, rd_price, rd_bid, rd_ask, count, wrapped,
           last_price, high_price, low_price, stats_valid
  );

  modport slave (
    input  match_signal, enable_count, trade_price, best_bid, best_ask, rd_en, rd_idx,
    output rd_valid, rd_hit, rd_price, rd_bid, rd_ask, count, wrapped,
           last_price, high_price, low_price, stats_valid
  );

endinterface

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-cycle trade event from the rising edge of the match level
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic match_i,
  input  logic enable_i,
  output logic event_o
);

  logic match_q;

  // Tracks the match level even while disabled, so re-enabling mid-match gives no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match_i;
  end

  assign event_o = match_i & ~match_q & enable_i;

endmodule

// File: rtl/trade_history.sv
// rtl/trade_history.sv - circular trade capture buffer with age-indexed read port
// Optional session statistics enabled by TRADE_HISTORY_STATS_EN.
module trade_history #(
  parameter int DEPTH   = 16,
  parameter int PRICE_W = trade_pkg::PRICE_W
) (
  input  logic           clk,
  input  logic           reset,
  trade_history_if.slave bus
);
  import trade_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic             evt;
  trade_entry_t     mem_q [DEPTH];
  trade_entry_t     wr_entry;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic [IDX_W-1:0] rd_slot;
  logic             rd_hit_d, rd_hit_q, rd_valid_q;
  trade_entry_t     rd_data_d, rd_data_q;

  rise_detect u_rise (
    .clk      (clk),
    .reset    (reset),
    .match_i  (bus.match_signal),
    .enable_i (bus.enable_count),
    .event_o  (evt)
  );

  assign wr_entry = {bus.trade_price, bus.best_bid, bus.best_ask};

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    if (evt) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q == (IDX_W+1)'(DEPTH)) wrapped_d = 1'b1;
      else                              count_d   = count_q + 1'b1;
    end
  end

  // Reads use pre-write pointer and count, so a same-cycle write is not visible yet.
  assign rd_slot   = wr_ptr_q - IDX_W'(1) - bus.rd_idx;
  assign rd_hit_d  = {1'b0, bus.rd_idx} < count_q;
  assign rd_data_d = rd_hit_d ? mem_q[rd_slot] : '0;

  always_ff @(posedge clk) begin
    if (evt) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_hit_q  <= rd_hit_d;
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_hit   = rd_hit_q;
  assign bus.rd_price = rd_data_q.price;
  assign bus.rd_bid   = rd_data_q.bid;
  assign bus.rd_ask   = rd_data_q.ask;
  assign bus.count    = count_q;
  assign bus.wrapped  = wrapped_q;

`ifdef TRADE_HISTORY_STATS_EN
  logic [PRICE_W-1:0] last_q, last_d, high_q, high_d, low_q, low_d;
  logic               stats_valid_q, stats_valid_d;

  always_comb begin
    last_d        = last_q;
    high_d        = high_q;
    low_d         = low_q;
    stats_valid_d = stats_valid_q;
    if (evt) begin
      last_d        = bus.trade_price;
      stats_valid_d = 1'b1;
      if (!stats_valid_q || bus.trade_price > high_q) high_d = bus.trade_price;
      if (!stats_valid_q || bus.trade_price < low_q)  low_d  = bus.trade_price;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q        <= PRICE_MIN;
      high_q        <= PRICE_MIN;
      low_q         <= PRICE_MAX;
      stats_valid_q <= 1'b0;
    end else begin
      last_q        <= last_d;
      high_q        <= high_d;
      low_q         <= low_d;
      stats_valid_q <= stats_valid_d;
    end
  end

  assign bus.last_price  = last_q;
  assign bus.high_price  = high_q;
  assign bus.low_price   = low_q;
  assign bus.stats_valid = stats_valid_q;
`else
  assign bus.last_price  = PRICE_MIN;
  assign bus.high_price  = PRICE_MIN;
  assign bus.low_price   = PRICE_MIN;
  assign bus.stats_valid = 1'b0;
`endif

endmodule

// File: tb/tb_trade_history.sv
// tb/tb_trade_history.sv - randomized and directed bench for trade_history against a queue model
module tb_trade_history;

  localparam int DEPTH   = 16;
  localparam int PRICE_W = 8;

  typedef struct {
    int p;
    int b;
    int a;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trade_history_if #(.DEPTH(DEPTH), .PRICE_W(PRICE_W)) bus ();

  trade_history #(.DEPTH(DEPTH), .PRICE_W(PRICE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: newest trade at the front of the queue.
  ent_t hist[$];
  bit   m_wrapped;
  bit   m_sv;
  int   m_last, m_hi, m_lo;
  bit   prev_match;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_wrapped  = 1'b0;
    m_sv       = 1'b0;
    m_last     = 0;
    m_hi       = 0;
    m_lo       = 255;
    prev_match = 1'b0;
  endtask

  task automatic check_state();
    check("count", int'(bus.count), hist.size());
    check("wrapped", int'(bus.wrapped), int'(m_wrapped));
`ifdef TRADE_HISTORY_STATS_EN
    check("last_price", int'(bus.last_price), m_last);
    check("high_price", int'(bus.high_price), m_hi);
    check("low_price", int'(bus.low_price), m_lo);
    check("stats_valid", int'(bus.stats_valid), int'(m_sv));
`else
    check("last_price", int'(bus.last_price), 0);
    check("high_price", int'(bus.high_price), 0);
    check("low_price", int'(bus.low_price), 0);
    check("stats_valid", int'(bus.stats_valid), 0);
`endif
  endtask

  // One clock: predict from pre-edge inputs and model, then compare after the edge.
  task automatic tick();
    bit ev, rd, ehit;
    int idx, ep, eb, ea, p, b, a;
    bit mlev;
    mlev = bus.match_signal;
    ev   = mlev && !prev_match && bus.enable_count;
    rd   = bus.rd_en;
    idx  = int'(bus.rd_idx);
    p = int'(bus.trade_price); b = int'(bus.best_bid); a = int'(bus.best_ask);
    ehit = idx < hist.size();
    ep = 0; eb = 0; ea = 0;
    if (ehit) begin
      ep = hist[idx].p; eb = hist[idx].b; ea = hist[idx].a;
    end
    @(posedge clk);
    #1;
    prev_match = mlev;
    if (ev) begin
      if (hist.size() == DEPTH) begin
        m_wrapped = 1'b1;
        void'(hist.pop_back());
      end
      hist.push_front('{p: p, b: b, a: a});
      m_last = p;
      if (!m_sv || p > m_hi) m_hi = p;
      if (!m_sv || p < m_lo) m_lo = p;
      m_sv = 1'b1;
    end
    check("rd_valid", int'(bus.rd_valid), int'(rd));
    if (rd) begin
      check("rd_hit", int'(bus.rd_hit), int'(ehit));
      check("rd_price", int'(bus.rd_price), ep);
      check("rd_bid", int'(bus.rd_bid), eb);
      check("rd_ask", int'(bus.rd_ask), ea);
    end
    check_state();
  endtask

  task automatic trade(input int p, input int b, input int a);
    bus.trade_price  = PRICE_W'(p);
    bus.best_bid     = PRICE_W'(b);
    bus.best_ask     = PRICE_W'(a);
    bus.match_signal = 1'b1;
    tick();
    bus.match_signal = 1'b0;
    tick();
  endtask

  task automatic read(input int idx);
    bus.rd_en  = 1'b1;
    bus.rd_idx = 4'(idx);
    tick();
    bus.rd_en  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_state();
    check("rd_valid_rst", int'(bus.rd_valid), 0);
    check("rd_hit_rst", int'(bus.rd_hit), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.match_signal = 1'b0;
    bus.enable_count = 1'b1;
    bus.trade_price  = '0;
    bus.best_bid     = '0;
    bus.best_ask     = '0;
    bus.rd_en        = 1'b0;
    bus.rd_idx       = '0;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    read(0);

    trade(50, 49, 51);
    trade(70, 69, 71);
    trade(40, 39, 41);
    read(0);
    read(2);
    read(3);

    bus.trade_price  = 8'd90;
    bus.match_signal = 1'b1;
    repeat (20) tick();
    bus.match_signal = 1'b0;
    tick();

    do_reset();
    for (int i = 1; i <= DEPTH + 2; i++) trade(i, i - 1, i + 1);
    read(0);
    read(15);

    bus.enable_count = 1'b0;
    trade(200, 199, 201);
    bus.match_signal = 1'b1;
    tick();
    bus.enable_count = 1'b1;
    repeat (3) tick();
    bus.match_signal = 1'b0;
    tick();

    trade(60, 59, 61);
    bus.trade_price  = 8'd65;
    bus.best_bid     = 8'd64;
    bus.best_ask     = 8'd66;
    bus.match_signal = 1'b1;
    bus.rd_en        = 1'b1;
    bus.rd_idx       = '0;
    tick();
    bus.match_signal = 1'b0;
    tick();
    bus.rd_en        = 1'b0;
    tick();

    trade(33, 32, 34);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      bus.match_signal = ($urandom_range(0, 2) == 0);
      bus.enable_count = ($urandom_range(0, 5) != 0);
      bus.trade_price  = PRICE_W'($urandom);
      bus.best_bid     = PRICE_W'($urandom);
      bus.best_ask     = PRICE_W'($urandom);
      bus.rd_en        = $urandom_range(0, 1) == 1;
      bus.rd_idx       = 4'($urandom);
      tick();
    end
    bus.match_signal = 1'b0;
    bus.rd_en        = 1'b0;
    for (int i = 0; i < DEPTH; i++) read(i);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trade_history.md
# trade_history

Circular capture buffer that sits directly downstream of the matching engine. It records one entry per executed trade: trade price, best bid and best ask at match time. It also keeps running session statistics. Its indexed read port lets a display or VGA stage fetch the N-th most recent trade.

## Interface
Parameters:
- DEPTH, 16, number of stored trades; power of two, 2..256
- PRICE_W, 8, width of every price field

Ports:
- clk  in  1  system clock (clk_50 domain)
- reset  in  1  asynchronous, active-high; clears all state
- match_signal  in  1  level match indication from matching engine
- enable_count  in  1  controller gate; trades are recorded only while high
- trade_price  in  PRICE_W  execution price
- best_bid  in  PRICE_W  best bid at match time
- best_ask  in  PRICE_W  best ask at match time
- rd_en  in  1  read request strobe
- rd_idx  in  $clog2(DEPTH)  age index; 0 is the newest trade
- rd_valid  out  1  one-cycle pulse carrying read result
- rd_hit  out  1  indexed entry exists (valid with rd_valid)
- rd_price, rd_bid, rd_ask  out  PRICE_W  entry fields (valid with rd_valid)
- count  out  $clog2(DEPTH)+1  stored entries, saturates at DEPTH
- wrapped  out  1  sticky; set on the first overwrite of an old entry
- last_price, high_price, low_price  out  PRICE_W  session statistics
- stats_valid  out  1  at least one trade recorded

## Operation
- Trade event = rising edge of match_signal (registered match_d), qualified with enable_count in the same cycle. A match level held for many cycles records exactly one trade.
- On an event, the block writes {trade_price, best_bid, best_ask} sampled in the event cycle to mem[wr_ptr]. Then wr_ptr increments modulo DEPTH and count increments, saturating at DEPTH.
- Event while count == DEPTH: the oldest entry is overwritten, count stays DEPTH, and wrapped sets (sticky until reset).
- Read: the slot is computed as (wr_ptr - 1 - rd_idx) mod DEPTH using pre-write pointer values.
- rd_hit = (rd_idx < count), evaluated with pre-write count. On a miss, the data outputs are 0.
- Simultaneous event and read: the read sees the pre-write state, so rd_idx 0 returns the previous newest trade.
- Stats: last_price is updated on every event. high_price = max and low_price = min over all recorded trades. The first trade loads all three.
- enable_count low: events are ignored, but match_d keeps tracking so that re-enabling mid-match does not create a false edge.
- Reset mid-operation: all pointers, counts, flags and statistics return to reset values at once. Memory contents need not clear; rd_hit masks stale data.

## Timing
- Reset values: rd_valid 0, rd_hit 0, rd_* data 0, count 0, wrapped 0, last_price 0, high_price 0, low_price all-ones, stats_valid 0.
- Write latency: count, statistics and memory update at the clock edge closing the event cycle. They are visible from the next cycle.
- Read latency: 1 cycle. rd_en in cycle N gives rd_valid, rd_hit and data in cycle N+1, held until the next read.
- Back-to-back reads every cycle are supported, one result per cycle.
- Minimum spacing between trade events is 2 cycles, because the match input must fall between edges.

## Configuration
- TRADE_HISTORY_STATS_EN defined: last/high/low tracking and stats_valid are implemented as above.
- Macro not defined: the statistics registers are removed. last_price, high_price and low_price are tied to 0, and stats_valid is tied to 0. The buffer and read port are unchanged.

## Structure
- Shared package trade_pkg: PRICE_W default, trade_entry_t struct {price, bid, ask}, PRICE_MIN/PRICE_MAX constants.
- One sub-module, rise_detect: registers match_d and outputs the qualified single-cycle event pulse.
- Storage is an inferred DEPTH-entry register array. It is small enough for LUT RAM or registers.

## Test plan
- Reset, then rd_en with rd_idx 0 -> rd_valid 1, rd_hit 0, data 0, count 0, low_price 0xFF.
- Three trades at prices 50, 70, 40 (bid/ask 49/51, 69/71, 39/41) -> count 3. Read idx0 gives 40/39/41; idx2 gives 50/49/51; idx3 gives a miss. Stats: high 70, low 40, last 40.
- match_signal held high for 20 cycles with enable_count 1 -> count increments by exactly 1.
- DEPTH+2 = 18 trades at prices 1..18 -> count 16, wrapped 1. idx0 gives price 18; idx15 gives price 3.
- Event with enable_count 0 -> count unchanged. enable_count rising while match is already high -> no entry recorded.
- Event and rd_en with idx0 in the same cycle after trade 60 -> the result returns 60, the next read returns the new trade. An asserted reset mid-sequence clears count and stats immediately.
